nand_sched: RTL and testbench
=============================

NAND_SCHED -- requirements
Module: nand_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the NAND unit; fixed at 4 for this release.
REQ-002 Parameter W, default 8, operand/result width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  NREQ  per-requester request; level, held until granted.
REQ-006 a_in  input  NREQ*W  operand A, requester i in bits [i*W +: W].
REQ-007 b_in  input  NREQ*W  operand B, same packing as a_in.
REQ-008 gnt  output  NREQ  one-hot grant pulse, one cycle; operands of the granted requester are captured that cycle.
REQ-009 res_valid  output  1  result available.
REQ-010 res_data  output  W  bitwise ~(A & B) of the granted pair.
REQ-011 res_id  output  2  index of the requester that owns res_data.
REQ-012 res_ready  input  1  consumer accepts the result when res_valid && res_ready.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 op_count  output  16  completed-transfer count, saturating at 16'hFFFF.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, EVAL and HOLD.
REQ-016 In IDLE with any req bit set, gnt SHALL assert combinationally for the first set bit at or after rr_ptr (wrapping NREQ-1 -> 0), operands SHALL be captured, and the next state SHALL be EVAL.
REQ-017 In IDLE with req == 0, gnt SHALL be 0 and the state SHALL remain IDLE.
REQ-018 On a grant to index k, rr_ptr SHALL become (k+1) mod NREQ; a requester SHALL NOT be granted twice while another requester stays asserted.
REQ-019 EVAL SHALL last one cycle and SHALL register res_data = ~(A & B) and res_id = k, then go to HOLD.
REQ-020 In HOLD, res_valid SHALL be 1, and res_data and res_id SHALL be stable until the handshake completes.
REQ-021 In HOLD with res_ready = 1, the state SHALL return to IDLE and op_count SHALL increment (saturating); with res_ready = 0, the state SHALL remain HOLD.
REQ-022 Latency SHALL be 2 cycles from the gnt cycle to the first res_valid cycle; minimum issue interval SHALL be 3 cycles.
REQ-023 gnt SHALL be 0 in EVAL and HOLD regardless of req.
REQ-024 res_valid SHALL be 0 outside HOLD; res_ready outside HOLD SHALL be ignored.
REQ-025 Deasserting req of a requester after its grant SHALL NOT affect the in-flight result.

Reset
REQ-026 With rst high at a clock edge, the state SHALL become IDLE, rr_ptr 0, res_data 0, res_id 0 and op_count 0.
REQ-027 While rst is high, gnt SHALL be 0, res_valid 0 and busy 0.
REQ-028 Reset in EVAL or HOLD SHALL discard the in-flight result without incrementing op_count.

Structure
REQ-029 The shared package SHALL hold the state enum (IDLE/EVAL/HOLD), NREQ, W and the op_count width.
REQ-030 The round-robin priority picker SHALL be one combinational sub-module, rr_pick (inputs req and rr_ptr; outputs one-hot gnt and index); all other logic SHALL be in nand_sched.

Verification
REQ-031 The bench SHALL apply reset, then req=4'b0001, A0=8'hF0, B0=8'h3C, res_ready=1; required: gnt=0001 in cycle 0, res_valid in cycle 2 with res_data=8'hCF and res_id=0, op_count=1.
REQ-032 The bench SHALL hold req=4'b1111 with res_ready=1; required: grants in the order 0,1,2,3,0 at 3-cycle spacing.
REQ-033 The bench SHALL hold res_ready=0 for 5 cycles in HOLD with A=8'hFF, B=8'hFF; required: res_valid held with res_data=8'h00 stable, no gnt, and op_count unchanged until res_ready=1.
REQ-034 The bench SHALL assert rst during HOLD; required: next cycle res_valid=0, busy=0, op_count unchanged from its pre-reset value (0), and rr_ptr=0, so req=4'b1010 grants index 1.
REQ-035 The bench SHALL drop req after the grant and change a_in during EVAL; required: res_data reflects the captured operands.
REQ-036 The bench SHALL preload op_count to 16'hFFFE via 2^16-2 transfers or force, then complete 3 transfers; required: op_count=16'hFFFF.

Source files
------------

// File: rtl/nand_sched_pkg.sv
// Shared types and sizes for the round-robin NAND scheduler.
// Imported by rr_pick and nand_sched.
package nand_sched_pkg;

   localparam int NREQ  = 4;
   localparam int W     = 8;
   localparam int IDX_W = 2;
   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker: first set request at or after rr_ptr.
// Purely combinational; the caller owns the pointer.
module rr_pick
   import nand_sched_pkg::*;
#(
   parameter int N = nand_sched_pkg::NREQ
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx
);

   logic [IDX_W-1:0] j;
   logic             found;

   // scan from rr_ptr upward, wrapping, and take the first hit
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      j     = '0;
      for (int i = 0; i < N; i++) begin
         j = rr_ptr + IDX_W'(i);
         if (!found && req[j]) begin
            found  = 1'b1;
            idx    = j;
            gnt[j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/nand_sched.sv
// Shares one registered NAND unit among NREQ requesters, round-robin.
// IDLE grants and captures, EVAL computes, HOLD waits for res_ready.
module nand_sched
   import nand_sched_pkg::*;
#(
   parameter int NREQ = nand_sched_pkg::NREQ,
   parameter int W    = nand_sched_pkg::W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] a_in,
   input  logic [NREQ*W-1:0] b_in,
   output logic [NREQ-1:0]   gnt,
   output logic              res_valid,
   output logic [W-1:0]      res_data,
   output logic [IDX_W-1:0]  res_id,
   input  logic              res_ready,
   output logic              busy,
   output logic [CNT_W-1:0]  op_count
);

   state_t           state;
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] k_q;
   logic [W-1:0]     a_q;
   logic [W-1:0]     b_q;
   logic [NREQ-1:0]  pick_gnt;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_any;

   rr_pick #(.N(NREQ)) u_pick (
      .req    (req),
      .rr_ptr (rr_ptr),
      .gnt    (pick_gnt),
      .idx    (pick_idx)
   );

   assign pick_any  = |req;
   assign gnt       = (state == IDLE && !rst) ? pick_gnt : '0;
   assign res_valid = (state == HOLD) && !rst;
   assign busy      = (state != IDLE) && !rst;

   // grant/capture, evaluate, then hold the result until accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         k_q      <= '0;
         a_q      <= '0;
         b_q      <= '0;
         res_data <= '0;
         res_id   <= '0;
         op_count <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pick_any) begin
                  a_q    <= a_in[pick_idx*W +: W];
                  b_q    <= b_in[pick_idx*W +: W];
                  k_q    <= pick_idx;
                  rr_ptr <= pick_idx + IDX_W'(1);
                  state  <= EVAL;
               end
            end
            EVAL: begin
               res_data <= ~(a_q & b_q);
               res_id   <= k_q;
               state    <= HOLD;
            end
            HOLD: begin
               if (res_ready) begin
                  state <= IDLE;
                  if (op_count != '1)
                     op_count <= op_count + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nand_sched.sv
// Directed bench for nand_sched: grants, latency, backpressure,
// reset abort, operand capture and counter saturation.
module tb_nand_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic [3:0]  gnt;
   logic        res_valid;
   logic [7:0]  res_data;
   logic [1:0]  res_id;
   logic        res_ready;
   logic        busy;
   logic [15:0] op_count;

   int n_chk  = 0;
   int n_pass = 0;

   logic [7:0] exp_nand [4];
   logic [3:0] exp_oh;
   logic [15:0] cnt_save;

   nand_sched dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .a_in      (a_in),
      .b_in      (b_in),
      .gnt       (gnt),
      .res_valid (res_valid),
      .res_data  (res_data),
      .res_id    (res_id),
      .res_ready (res_ready),
      .busy      (busy),
      .op_count  (op_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // advance one cycle and land 1ns after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      req       = '0;
      a_in      = '0;
      b_in      = '0;
      res_ready = 1'b0;

      // reset state, checked while rst is still high
      step();
      step();
      #1;
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_valid", 32'(res_valid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_cnt", 32'(op_count), 32'h0);
      chk("rst_data", 32'(res_data), 32'h0);
      chk("rst_id", 32'(res_id), 32'h0);
      rst = 1'b0;
      step();

      // single transfer from requester 0
      req       = 4'b0001;
      a_in      = 32'h0000_00F0;
      b_in      = 32'h0000_003C;
      res_ready = 1'b1;
      #1;
      chk("t1_gnt_c0", 32'(gnt), 32'h1);
      step();
      req = 4'b0000;
      #1;
      chk("t1_gnt_c1", 32'(gnt), 32'h0);
      chk("t1_valid_c1", 32'(res_valid), 32'h0);
      chk("t1_busy_c1", 32'(busy), 32'h1);
      step();
      chk("t1_valid_c2", 32'(res_valid), 32'h1);
      chk("t1_data", 32'(res_data), 32'hCF);
      chk("t1_id", 32'(res_id), 32'h0);
      step();
      chk("t1_cnt", 32'(op_count), 32'h1);
      chk("t1_busy_done", 32'(busy), 32'h0);

      // round robin with every requester asserted
      do_reset();
      a_in = {8'h0F, 8'h33, 8'h55, 8'hF0};
      b_in = {8'hFF, 8'h0F, 8'hAA, 8'h3C};
      exp_nand[0] = 8'hCF;
      exp_nand[1] = 8'hFF;
      exp_nand[2] = 8'hFC;
      exp_nand[3] = 8'hF0;
      req       = 4'b1111;
      res_ready = 1'b1;
      #1;
      for (int g = 0; g < 5; g++) begin
         exp_oh = 4'b0001 << (g % 4);
         chk("rr_gnt", 32'(gnt), 32'(exp_oh));
         step();
         chk("rr_gnt_eval", 32'(gnt), 32'h0);
         step();
         chk("rr_gnt_hold", 32'(gnt), 32'h0);
         chk("rr_valid", 32'(res_valid), 32'h1);
         chk("rr_id", 32'(res_id), 32'(g % 4));
         chk("rr_data", 32'(res_data), 32'(exp_nand[g % 4]));
         step();
      end
      chk("rr_cnt", 32'(op_count), 32'd5);

      // backpressure: result held for five cycles
      req       = 4'b0001;
      a_in      = 32'h0000_00FF;
      b_in      = 32'h0000_00FF;
      res_ready = 1'b0;
      #1;
      chk("bp_gnt", 32'(gnt), 32'h1);
      step();
      req = 4'b1111;
      step();
      for (int c = 0; c < 5; c++) begin
         chk("bp_valid", 32'(res_valid), 32'h1);
         chk("bp_data", 32'(res_data), 32'h00);
         chk("bp_gnt_hold", 32'(gnt), 32'h0);
         chk("bp_cnt", 32'(op_count), 32'd5);
         step();
      end
      res_ready = 1'b1;
      req       = 4'b0000;
      #1;
      chk("bp_valid_last", 32'(res_valid), 32'h1);
      step();
      chk("bp_cnt_done", 32'(op_count), 32'd6);
      chk("bp_valid_done", 32'(res_valid), 32'h0);

      // reset in HOLD discards the result and clears the pointer
      do_reset();
      req       = 4'b0100;
      a_in      = 32'h00FF_0000;
      b_in      = 32'h00FF_0000;
      res_ready = 1'b0;
      #1;
      chk("ra_gnt", 32'(gnt), 32'h4);
      step();
      req = 4'b0000;
      step();
      chk("ra_valid", 32'(res_valid), 32'h1);
      rst = 1'b1;
      step();
      chk("ra_valid_rst", 32'(res_valid), 32'h0);
      chk("ra_busy_rst", 32'(busy), 32'h0);
      chk("ra_cnt_rst", 32'(op_count), 32'h0);
      rst       = 1'b0;
      req       = 4'b1010;
      res_ready = 1'b1;
      #1;
      chk("ra_gnt_after", 32'(gnt), 32'h2);
      step();
      req = 4'b0000;
      step();
      chk("ra_id", 32'(res_id), 32'h1);
      step();
      chk("ra_cnt", 32'(op_count), 32'h1);

      // operands captured at grant, later changes ignored
      req  = 4'b0001;
      a_in = 32'h0000_00AA;
      b_in = 32'h0000_000F;
      #1;
      chk("cap_gnt", 32'(gnt), 32'h1);
      step();
      req  = 4'b0000;
      a_in = 32'h0;
      b_in = 32'h0;
      step();
      chk("cap_data", 32'(res_data), 32'hF5);
      chk("cap_id", 32'(res_id), 32'h0);
      step();

      // counter saturation
      force dut.op_count = 16'hFFFE;
      #1;
      release dut.op_count;
      #1;
      chk("sat_preload", 32'(op_count), 32'hFFFE);
      a_in = 32'h0000_0011;
      b_in = 32'h0000_0022;
      res_ready = 1'b1;
      for (int t = 0; t < 3; t++) begin
         req = 4'b0001;
         step();
         req = 4'b0000;
         step();
         chk("sat_data", 32'(res_data), 32'hFF);
         step();
         chk("sat_cnt", 32'(op_count), 32'hFFFF);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
